// File: rtl/stream_pkg.sv
// Shared FSM state encoding and parameter defaults for the QoS stream demux.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    localparam int DEF_T_DATA_WIDTH = 4;
    localparam int DEF_T_QOS__WIDTH = 2;
    localparam int DEF_STREAM_COUNT = 2;

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready register slice; 1-cycle latency, full throughput.
// Accepts a new beat when empty or when the held beat leaves in the same cycle.
module stream_reg_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_dat,
    input  logic         in_vld,
    output logic         in_rdy,
    output logic [W-1:0] out_dat,
    output logic         out_vld,
    input  logic         out_rdy
);

    logic         vld_q;
    logic [W-1:0] dat_q;

    assign in_rdy  = !vld_q || out_rdy;
    assign out_vld = vld_q;
    assign out_dat = dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else if (in_rdy) begin
            vld_q <= in_vld;
            if (in_vld) begin
                dat_q <= in_dat;
            end
        end
    end

endmodule

// File: rtl/stream_demux_w_qos.sv
// Packet demux: first beat's id locks the route, out-of-range ids drop the packet; 1-cycle latency.
// Backpressure from the selected output stalls the input; a packet being dropped is always accepted.
module stream_demux_w_qos
    import stream_pkg::*;
#(
    parameter int T_DATA_WIDTH = DEF_T_DATA_WIDTH,
    parameter int T_QOS__WIDTH = DEF_T_QOS__WIDTH,
    parameter int STREAM_COUNT = DEF_STREAM_COUNT,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [T_DATA_WIDTH-1:0]                    s_data_in,
    input  logic [T_QOS__WIDTH-1:0]                    s_qos_in,
    input  logic [T_ID___WIDTH-1:0]                    s_id_in,
    input  logic                                       s_last_in,
    input  logic                                       s_valid_in,
    output logic                                       s_ready_out,
    output logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0]  m_data_out,
    output logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0]  m_qos_out,
    output logic [STREAM_COUNT-1:0]                    m_last_out,
    output logic [STREAM_COUNT-1:0]                    m_valid_out,
    input  logic [STREAM_COUNT-1:0]                    m_ready_in,
    output logic                                       drop_pulse_out
);

    typedef struct packed {
        logic [T_DATA_WIDTH-1:0] dat;
        logic [T_QOS__WIDTH-1:0] qos;
        logic                    last;
        logic [T_ID___WIDTH-1:0] id;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    state_t                  state;
    logic [T_ID___WIDTH-1:0] route_id;
    logic                    id_ok;
    logic                    route_beat;
    logic                    accept;
    logic                    slice_in_vld;
    logic                    slice_in_rdy;
    logic                    slice_out_vld;
    logic                    sel_rdy;
    beat_t                   in_beat;
    beat_t                   buf_beat;

    assign id_ok = 32'(s_id_in) < 32'(STREAM_COUNT);

    // A beat reaches the register only while routing or when it opens a routable packet.
    assign route_beat   = (state == ROUTE) || ((state == IDLE) && id_ok);
    assign s_ready_out  = !rst && ((state == DROP) || slice_in_rdy);
    assign accept       = s_valid_in && s_ready_out;
    assign slice_in_vld = s_valid_in && !rst && route_beat;

    // Discarded beats are either in DROP or open an unroutable packet in IDLE.
    assign drop_pulse_out = accept && s_last_in && !route_beat;

    always_comb begin
        in_beat      = '0;
        in_beat.dat  = s_data_in;
        in_beat.qos  = s_qos_in;
        in_beat.last = s_last_in;
        in_beat.id   = (state == ROUTE) ? route_id : s_id_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            route_id <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (id_ok) begin
                        route_id <= s_id_in;
                        state    <= s_last_in ? IDLE : ROUTE;
                    end else begin
                        state    <= s_last_in ? IDLE : DROP;
                    end
                end
                ROUTE, DROP: begin
                    if (s_last_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    stream_reg_slice #(
        .W (BEAT_W)
    ) u_slice (
        .clk     (clk),
        .rst     (rst),
        .in_dat  (in_beat),
        .in_vld  (slice_in_vld),
        .in_rdy  (slice_in_rdy),
        .out_dat (buf_beat),
        .out_vld (slice_out_vld),
        .out_rdy (sel_rdy)
    );

    // Only the destination of the held beat may release it.
    always_comb begin
        sel_rdy = 1'b0;
        for (int i = 0; i < STREAM_COUNT; i++) begin
            if ((buf_beat.id == T_ID___WIDTH'(i)) && m_ready_in[i]) begin
                sel_rdy = 1'b1;
            end
        end
    end

    always_comb begin
        m_data_out  = '0;
        m_qos_out   = '0;
        m_last_out  = '0;
        m_valid_out = '0;
        for (int i = 0; i < STREAM_COUNT; i++) begin
            if (slice_out_vld && !rst && (buf_beat.id == T_ID___WIDTH'(i))) begin
                m_valid_out[i] = 1'b1;
                m_data_out[i]  = buf_beat.dat;
                m_qos_out[i]   = buf_beat.qos;
                m_last_out[i]  = buf_beat.last;
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_w_qos.sv
// Directed bench for stream_demux_w_qos with three outputs so out-of-range ids can be exercised.
module tb_stream_demux_w_qos;

    localparam int DW = 4;
    localparam int QW = 2;
    localparam int SC = 3;
    localparam int IW = 2;

    logic                  clk;
    logic                  rst;
    logic [DW-1:0]         s_data_in;
    logic [QW-1:0]         s_qos_in;
    logic [IW-1:0]         s_id_in;
    logic                  s_last_in;
    logic                  s_valid_in;
    logic                  s_ready_out;
    logic [SC-1:0][DW-1:0] m_data_out;
    logic [SC-1:0][QW-1:0] m_qos_out;
    logic [SC-1:0]         m_last_out;
    logic [SC-1:0]         m_valid_out;
    logic [SC-1:0]         m_ready_in;
    logic                  drop_pulse_out;

    int total;
    int passed;

    stream_demux_w_qos #(
        .T_DATA_WIDTH (DW),
        .T_QOS__WIDTH (QW),
        .STREAM_COUNT (SC),
        .T_ID___WIDTH (IW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_data_in      (s_data_in),
        .s_qos_in       (s_qos_in),
        .s_id_in        (s_id_in),
        .s_last_in      (s_last_in),
        .s_valid_in     (s_valid_in),
        .s_ready_out    (s_ready_out),
        .m_data_out     (m_data_out),
        .m_qos_out      (m_qos_out),
        .m_last_out     (m_last_out),
        .m_valid_out    (m_valid_out),
        .m_ready_in     (m_ready_in),
        .drop_pulse_out (drop_pulse_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1ns after the edge; checks run 2ns later, well clear of either edge.
    task automatic drive(input logic v, input logic [IW-1:0] id, input logic [DW-1:0] d,
                         input logic [QW-1:0] q, input logic l);
        s_valid_in = v;
        s_id_in    = id;
        s_data_in  = d;
        s_qos_in   = q;
        s_last_in  = l;
        #2;
    endtask

    initial begin
        total      = 0;
        passed     = 0;
        rst        = 1'b1;
        m_ready_in = 3'b111;
        drive(1'b0, 2'd0, 4'h0, 2'd0, 1'b0);
        tick();
        drive(1'b1, 2'd1, 4'hF, 2'd3, 1'b0);
        chk("rst_ready", 32'(s_ready_out), 32'h0);
        chk("rst_valid", 32'(m_valid_out), 32'h0);
        chk("rst_data", 32'(m_data_out), 32'h0);
        chk("rst_drop", 32'(drop_pulse_out), 32'h0);
        tick();

        // First cycle out of reset
        rst = 1'b0;
        drive(1'b0, 2'd0, 4'h0, 2'd0, 1'b0);
        chk("post_rst_ready", 32'(s_ready_out), 32'h1);
        chk("post_rst_valid", 32'(m_valid_out), 32'h0);
        tick();

        // Route: id=1, beats B then D(last)
        drive(1'b1, 2'd1, 4'hB, 2'd1, 1'b0);
        chk("route_rdy0", 32'(s_ready_out), 32'h1);
        chk("route_v0", 32'(m_valid_out), 32'h0);
        tick();
        drive(1'b1, 2'd1, 4'hD, 2'd2, 1'b1);
        chk("route_v1", 32'(m_valid_out), 32'b010);
        chk("route_d1", 32'(m_data_out[1]), 32'hB);
        chk("route_q1", 32'(m_qos_out[1]), 32'h1);
        chk("route_l1", 32'(m_last_out), 32'b000);
        chk("route_zero0", 32'(m_data_out[0]), 32'h0);
        chk("route_rdy1", 32'(s_ready_out), 32'h1);
        tick();
        drive(1'b0, 2'd0, 4'h0, 2'd0, 1'b0);
        chk("route_v2", 32'(m_valid_out), 32'b010);
        chk("route_d2", 32'(m_data_out[1]), 32'hD);
        chk("route_q2", 32'(m_qos_out[1]), 32'h2);
        chk("route_l2", 32'(m_last_out), 32'b010);
        tick();
        chk("route_v3", 32'(m_valid_out), 32'h0);

        // Lock: second beat's id must be ignored
        drive(1'b1, 2'd0, 4'h9, 2'd0, 1'b0);
        tick();
        drive(1'b1, 2'd1, 4'h8, 2'd0, 1'b1);
        chk("lock_v1", 32'(m_valid_out), 32'b001);
        chk("lock_d1", 32'(m_data_out[0]), 32'h9);
        tick();
        drive(1'b0, 2'd0, 4'h0, 2'd0, 1'b0);
        chk("lock_v2", 32'(m_valid_out), 32'b001);
        chk("lock_d2", 32'(m_data_out[0]), 32'h8);
        chk("lock_l2", 32'(m_last_out), 32'b001);
        tick();
        chk("lock_v3", 32'(m_valid_out), 32'h0);

        // Backpressure on output 0 for 3 cycles mid-packet; other readies must not matter
        drive(1'b1, 2'd0, 4'h1, 2'd1, 1'b0);
        chk("bp_rdy0", 32'(s_ready_out), 32'h1);
        tick();
        m_ready_in = 3'b110;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'd0, 4'h2, 2'd1, 1'b0);
            chk("bp_stall_rdy", 32'(s_ready_out), 32'h0);
            chk("bp_stall_v", 32'(m_valid_out), 32'b001);
            chk("bp_stall_d", 32'(m_data_out[0]), 32'h1);
            tick();
        end
        m_ready_in = 3'b111;
        drive(1'b1, 2'd0, 4'h2, 2'd1, 1'b0);
        chk("bp_rel_rdy", 32'(s_ready_out), 32'h1);
        chk("bp_rel_d", 32'(m_data_out[0]), 32'h1);
        tick();
        drive(1'b1, 2'd0, 4'h3, 2'd1, 1'b0);
        chk("bp_d2", 32'(m_data_out[0]), 32'h2);
        tick();
        drive(1'b1, 2'd0, 4'h4, 2'd1, 1'b1);
        chk("bp_d3", 32'(m_data_out[0]), 32'h3);
        tick();
        drive(1'b0, 2'd0, 4'h0, 2'd0, 1'b0);
        chk("bp_d4", 32'(m_data_out[0]), 32'h4);
        chk("bp_l4", 32'(m_last_out), 32'b001);
        tick();
        chk("bp_done", 32'(m_valid_out), 32'h0);

        // Back-to-back single-beat packets
        drive(1'b1, 2'd0, 4'h5, 2'd0, 1'b1);
        chk("b2b_rdy0", 32'(s_ready_out), 32'h1);
        tick();
        drive(1'b1, 2'd1, 4'h6, 2'd3, 1'b1);
        chk("b2b_rdy1", 32'(s_ready_out), 32'h1);
        chk("b2b_v0", 32'(m_valid_out), 32'b001);
        chk("b2b_d0", 32'(m_data_out[0]), 32'h5);
        tick();
        drive(1'b0, 2'd0, 4'h0, 2'd0, 1'b0);
        chk("b2b_v1", 32'(m_valid_out), 32'b010);
        chk("b2b_d1", 32'(m_data_out[1]), 32'h6);
        chk("b2b_q1", 32'(m_qos_out[1]), 32'h3);
        tick();
        chk("b2b_done", 32'(m_valid_out), 32'h0);

        // Drop: id=3, three beats, later beats carry a valid id that must be ignored
        drive(1'b1, 2'd3, 4'hA, 2'd0, 1'b0);
        chk("drop_rdy0", 32'(s_ready_out), 32'h1);
        chk("drop_p0", 32'(drop_pulse_out), 32'h0);
        tick();
        m_ready_in = 3'b000;
        drive(1'b1, 2'd0, 4'hB, 2'd0, 1'b0);
        chk("drop_rdy1", 32'(s_ready_out), 32'h1);
        chk("drop_v1", 32'(m_valid_out), 32'h0);
        chk("drop_p1", 32'(drop_pulse_out), 32'h0);
        tick();
        drive(1'b1, 2'd0, 4'hC, 2'd0, 1'b1);
        chk("drop_rdy2", 32'(s_ready_out), 32'h1);
        chk("drop_p2", 32'(drop_pulse_out), 32'h1);
        chk("drop_v2", 32'(m_valid_out), 32'h0);
        tick();
        m_ready_in = 3'b111;
        drive(1'b1, 2'd2, 4'h7, 2'd1, 1'b1);
        chk("drop_p3", 32'(drop_pulse_out), 32'h0);
        chk("drop_v3", 32'(m_valid_out), 32'h0);
        tick();
        drive(1'b1, 2'd3, 4'hE, 2'd0, 1'b1);
        chk("drop1_p", 32'(drop_pulse_out), 32'h1);
        chk("after_drop_v", 32'(m_valid_out), 32'b100);
        chk("after_drop_d", 32'(m_data_out[2]), 32'h7);
        tick();
        drive(1'b0, 2'd0, 4'h0, 2'd0, 1'b0);
        chk("drop1_v", 32'(m_valid_out), 32'h0);
        chk("drop1_p_end", 32'(drop_pulse_out), 32'h0);
        tick();

        // Reset after the first beat of a 3-beat packet to output 1
        drive(1'b1, 2'd1, 4'h1, 2'd0, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b0, 2'd0, 4'h0, 2'd0, 1'b0);
        chk("mid_rst_v", 32'(m_valid_out), 32'h0);
        chk("mid_rst_d", 32'(m_data_out), 32'h0);
        chk("mid_rst_rdy", 32'(s_ready_out), 32'h0);
        tick();
        rst = 1'b0;
        drive(1'b1, 2'd2, 4'hE, 2'd2, 1'b1);
        chk("post_mid_v", 32'(m_valid_out), 32'h0);
        chk("post_mid_rdy", 32'(s_ready_out), 32'h1);
        tick();
        drive(1'b0, 2'd0, 4'h0, 2'd0, 1'b0);
        chk("post_mid_route", 32'(m_valid_out), 32'b100);
        chk("post_mid_d", 32'(m_data_out[2]), 32'hE);
        tick();
        chk("post_mid_done", 32'(m_valid_out), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stream_demux_w_qos.md
STREAM_DEMUX_W_QOS -- requirements
Module: stream_demux_w_qos

Interface
REQ-001 Parameter T_DATA_WIDTH, default 4, data width in bits.
REQ-002 Parameter T_QOS__WIDTH, default 2, QoS field width in bits.
REQ-003 Parameter STREAM_COUNT, default 2, number of output streams.
REQ-004 Parameter T_ID___WIDTH, default $clog2(STREAM_COUNT), destination id width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 s_data_in  in  T_DATA_WIDTH  input beat data.
REQ-009 s_qos_in  in  T_QOS__WIDTH  input beat QoS.
REQ-010 s_id_in  in  T_ID___WIDTH  destination stream index.
REQ-011 s_last_in  in  1  final beat of packet.
REQ-012 s_valid_in  in  1  input beat valid.
REQ-013 s_ready_out  out  1  input beat accepted when high with s_valid_in.
REQ-014 m_data_out  out  [STREAM_COUNT] x T_DATA_WIDTH  per-output data.
REQ-015 m_qos_out  out  [STREAM_COUNT] x T_QOS__WIDTH  per-output QoS.
REQ-016 m_last_out  out  STREAM_COUNT  per-output last.
REQ-017 m_valid_out  out  STREAM_COUNT  per-output valid.
REQ-018 m_ready_in  in  STREAM_COUNT  per-output ready.
REQ-019 drop_pulse_out  out  1  one-cycle pulse on the cycle a dropped packet's last beat is accepted.

Function
REQ-020 A transfer SHALL occur on any port when valid and ready are both high at a rising clk edge.
REQ-021 The FSM SHALL have states IDLE (between packets), ROUTE (packet locked to one output), DROP (packet being discarded).
REQ-022 In IDLE, an accepted beat with s_id_in < STREAM_COUNT SHALL latch s_id_in as the route id and enter ROUTE; if s_last_in is also high, the FSM SHALL stay in IDLE.
REQ-023 In IDLE, an accepted beat with s_id_in >= STREAM_COUNT SHALL be discarded and enter DROP; if s_last_in is also high, the FSM SHALL stay in IDLE and pulse drop_pulse_out.
REQ-024 In ROUTE, all beats SHALL go to the latched id regardless of s_id_in; an accepted beat with s_last_in high SHALL return the FSM to IDLE.
REQ-025 In DROP, s_ready_out SHALL be 1, accepted beats SHALL be discarded, and accepting s_last_in SHALL return the FSM to IDLE and pulse drop_pulse_out.
REQ-026 The output stage SHALL be a single-entry register holding data, QoS, last and id.
REQ-027 Latency from input acceptance to output valid SHALL be exactly 1 cycle.
REQ-028 In IDLE and ROUTE, s_ready_out SHALL be high when the register is empty or its held beat is transferring this cycle (!buf_valid || m_ready_in[buf_id]).
REQ-029 The block SHALL sustain one beat per cycle when the destination holds ready high.
REQ-030 m_valid_out[i] SHALL equal buf_valid && buf_id==i; at most one bit SHALL be high at a time.
REQ-031 m_data_out, m_qos_out and m_last_out of non-selected outputs SHALL be driven to zero.
REQ-032 While m_valid_out[i] is high and m_ready_in[i] is low, outputs SHALL hold stable; ready of non-selected outputs SHALL have no effect.
REQ-033 The block SHALL neither reorder nor duplicate beats, and beats SHALL pass through unmodified.

Reset
REQ-034 While rst is high: FSM in IDLE, buf_valid=0, all m_*_out=0, s_ready_out=0, drop_pulse_out=0.
REQ-035 Reset mid-packet SHALL abandon the packet, and no buffered beat SHALL be delivered after reset.
REQ-036 The first cycle after reset deassertion SHALL have s_ready_out=1.

Structure
REQ-037 Package stream_pkg SHALL hold the FSM state enum (IDLE, ROUTE, DROP) and the parameter defaults.
REQ-038 The output register SHALL be a sub-module stream_reg_slice (one entry, valid/ready, payload width parameter).

Verification
REQ-039 Route: id=1, 2-beat packet 0xB then 0xD with last, all m_ready_in=1 -> m_valid_out=2'b10 for 2 consecutive cycles, data B,D, last on D, 1-cycle latency.
REQ-040 Lock: packet starts with id=0, data 0x9; second beat data 0x8, s_id_in=1, last -> both beats appear only on output 0.
REQ-041 Backpressure: m_ready_in[0]=0 for 3 cycles mid-packet -> s_ready_out low after 1 buffered beat, output 0 stable, no beat loss or duplication after release.
REQ-042 Drop: STREAM_COUNT=3, T_ID___WIDTH=2, id=3, 3-beat packet -> s_ready_out=1 throughout, no m_valid_out, drop_pulse_out for one cycle on last beat.
REQ-043 Back-to-back: single-beat packets id=0 then id=1 on consecutive cycles -> no bubble; outputs 0 then 1 each valid for one cycle.
REQ-044 Reset mid-packet: rst high for 1 cycle after beat 1 of a 3-beat packet -> all outputs 0; next packet routes by its own first-beat id.
